// File: rtl/tnaf_digit_ctrl.sv
// tau-NAF digit generation sequencer: walks the remainder through check, mask, emit,
// subtract and divide-by-tau steps, streams one signed digit per iteration and stops on
// a zero remainder (DONE) or on a runaway digit count (ERR).
module tnaf_digit_ctrl #(
  parameter int unsigned MAX_DIGITS = 290,
  parameter int unsigned CNT_W      = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             load_en_o,
  input  logic             r_zero_i,
  input  logic             r_odd_i,
  output logic             mask_d_en_o,
  output logic             terminal_condition_o,
  input  logic             tbit_i,
  output logic             sub_en_o,
  output logic             div_en_o,
  output logic             digit_valid_o,
  input  logic             digit_ready_i,
  output logic             digit_nz_o,
  output logic             digit_sign_o,
  output logic [CNT_W-1:0] digit_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_overflow_o
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StCheck, StMask1, StMask2, StEmit, StSub, StDiv, StFinal, StDone, StErr
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic             nz_q, nz_d, sign_q, sign_d, first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d, done_q, done_d;
  logic             load_q, mask_q, term_q, sub_q, div_q;
  logic             idle_like, start_acc, emit_sign;

  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  assign start_acc = idle_like & start_i & ~abort_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // Masking unit presents the final Tbit in the first EMIT cycle; zero digits carry no sign.
  assign emit_sign = nz_q & tbit_i;

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start_i) state_d = StLoad;
      StLoad:  state_d = StCheck;
      StCheck: begin
        if (r_zero_i)     state_d = StFinal;
        else if (r_odd_i) state_d = StMask1;
        else              state_d = StEmit;
      end
      StMask1: state_d = StMask2;
      StMask2: state_d = StEmit;
      StEmit:  if (digit_ready_i) state_d = nz_q ? StSub : StDiv;
      StSub:   state_d = StDiv;
      StDiv:   state_d = (cnt_inc == MaxCnt) ? StErr : StCheck;
      StFinal: state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  // Digit bookkeeping: nz latch, held sign, digit counter, sticky overflow, done pulse.
  always_comb begin
    nz_d    = nz_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == StCheck) nz_d = ~r_zero_i & r_odd_i;
    if (start_acc) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == StDiv && !abort_i) begin
      cnt_d = cnt_inc;
      if (state_d == StErr) err_d = 1'b1;
    end
    first_d = (state_d == StEmit) && (state_q != StEmit);
    sign_d  = first_q ? emit_sign : sign_q;
    done_d  = (state_d == StDone) && (state_q != StDone);
  end

  // State, bookkeeping and registered strobe decodes of the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      nz_q    <= 1'b0;
      sign_q  <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      mask_q  <= 1'b0;
      term_q  <= 1'b0;
      sub_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nz_q    <= nz_d;
      sign_q  <= sign_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      load_q  <= (state_d == StLoad);
      mask_q  <= (state_d == StMask1) || (state_d == StMask2) || (state_d == StFinal);
      term_q  <= (state_d == StFinal);
      sub_q   <= (state_d == StSub);
      div_q   <= (state_d == StDiv);
    end
  end

  // Output decode; sign comes straight from tbit in the first EMIT cycle, then from the hold reg.
  always_comb begin
    load_en_o            = load_q;
    mask_d_en_o          = mask_q;
    terminal_condition_o = term_q;
    sub_en_o             = sub_q;
    div_en_o             = div_q;
    digit_valid_o        = (state_q == StEmit);
    digit_nz_o           = digit_valid_o & nz_q;
    digit_sign_o         = digit_valid_o & (first_q ? emit_sign : sign_q);
    digit_cnt_o          = cnt_q;
    busy_o               = ~idle_like;
    done_o               = done_q;
    err_overflow_o       = err_q;
  end

endmodule

// File: tb/tb_tnaf_digit_ctrl.sv
// Bench for tnaf_digit_ctrl: a queue of signed digits stands in for the remainder datapath;
// expected results come from the digit list and the digit limit.
module tb_tnaf_digit_ctrl;
  localparam int unsigned M  = 4;
  localparam int unsigned CW = 9;

  logic clk = 1'b0;
  logic rst, start, abort, r_zero, r_odd, tbit, digit_ready;
  logic load_en, mask_d_en, term, sub_en, div_en, digit_valid, digit_nz, digit_sign;
  logic busy, done, err;
  logic [CW-1:0] digit_cnt;

  always #5 clk = ~clk;

  tnaf_digit_ctrl #(.MAX_DIGITS(M), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .load_en_o(load_en),
    .r_zero_i(r_zero), .r_odd_i(r_odd), .mask_d_en_o(mask_d_en),
    .terminal_condition_o(term), .tbit_i(tbit), .sub_en_o(sub_en), .div_en_o(div_en),
    .digit_valid_o(digit_valid), .digit_ready_i(digit_ready), .digit_nz_o(digit_nz),
    .digit_sign_o(digit_sign), .digit_cnt_o(digit_cnt), .busy_o(busy), .done_o(done),
    .err_overflow_o(err)
  );

  int errors = 0, checks = 0;
  // Digit codes: bit0 = nonzero, bit1 = negative.
  logic [1:0] pend[$];
  logic [1:0] rem[$];
  logic [1:0] obs[$];
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: manual
  logic man_ready = 1'b0, rnd_ready = 1'b1;
  logic head_neg, valid_seen = 1'b0;
  logic last_valid = 1'b0, last_ready = 1'b0, last_nz = 1'b0, last_sign = 1'b0;
  int   n_load = 0, n_mask = 0, n_term = 0, n_sub = 0, n_div = 0, n_done = 0;
  int   n_onehot_bad = 0, n_stab_bad = 0;

  assign digit_ready = (rdy_mode == 2) ? man_ready : rnd_ready;

  // Datapath stand-in and strobe counting, mid-cycle.
  always @(negedge clk) begin
    if (load_en) rem = pend;
    if (load_en) n_load++;
    if (mask_d_en) n_mask++;
    if (term) n_term++;
    if (sub_en) n_sub++;
    if (div_en) n_div++;
    if (done) n_done++;
    if (int'(load_en) + int'(sub_en) + int'(div_en) > 1) n_onehot_bad++;
    if (div_en && rem.size() != 0) void'(rem.pop_front());
    if (rem.size() != 0) begin
      r_zero = 1'b0; r_odd = rem[0][0]; head_neg = rem[0][1];
    end else begin
      r_zero = 1'b1; r_odd = 1'b0; head_neg = 1'b0;
    end
    // After the first EMIT cycle tbit is scrambled: the emitted sign must be the held one.
    if (digit_valid && valid_seen) tbit = 1'($urandom);
    else                           tbit = head_neg;
    valid_seen = digit_valid;
    rnd_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  // Handshake capture and stall-stability tracking at the active edge.
  always @(posedge clk) begin
    if (!rst && last_valid && !last_ready)
      if (!digit_valid || digit_nz != last_nz || digit_sign != last_sign) n_stab_bad++;
    if (digit_valid && digit_ready) obs.push_back({digit_sign, digit_nz});
    last_valid = digit_valid; last_ready = digit_ready;
    last_nz = digit_nz; last_sign = digit_sign;
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int vec();
    return int'({load_en, mask_d_en, term, sub_en, div_en, digit_valid, digit_nz, digit_sign,
                 busy, done});
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic expv(input string name, input logic [9:0] e);
    chk(name, vec(), int'(e));
  endtask

  // Leaves the caller at the check point of cycle 1 (first cycle after the start edge).
  task automatic start_pulse();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic do_run(input string name, output int cnt, output int er, output int dn,
                        output int sb, output int dv, output int mk, output int tm);
    int b_done = n_done, b_sub = n_sub, b_div = n_div, b_mask = n_mask, b_term = n_term;
    int b_load = n_load, b_oh = n_onehot_bad, b_st = n_stab_bad;
    int o0 = obs.size();
    int w = 0, lp, n, bad = 0;
    start_pulse();
    while (busy && w < 500) begin step(); w++; end
    chk({name, " terminates"}, int'(w < 500), 1);
    step(); step();
    cnt = int'(digit_cnt); er = int'(err); dn = n_done - b_done;
    sb = n_sub - b_sub; dv = n_div - b_div; mk = n_mask - b_mask; tm = n_term - b_term;
    lp = pend.size();
    n = (lp < int'(M)) ? lp : int'(M);
    chk({name, " digits emitted"}, obs.size() - o0, n);
    for (int i = 0; i < n && o0 + i < obs.size(); i++) if (obs[o0 + i] != pend[i]) bad++;
    chk({name, " digit values"}, bad, 0);
    chk({name, " load pulses"}, n_load - b_load, 1);
    chk({name, " strobe overlap"}, n_onehot_bad - b_oh, 0);
    chk({name, " stall stability"}, n_stab_bad - b_st, 0);
  endtask

  // Expectations derived from the digit list alone.
  task automatic run_model(input string name);
    int cnt, er, dn, sb, dv, mk, tm, lp, n, nz = 0, fin;
    lp = pend.size();
    n = (lp < int'(M)) ? lp : int'(M);
    for (int i = 0; i < n; i++) if (pend[i][0]) nz++;
    fin = (lp < int'(M)) ? 1 : 0;
    do_run(name, cnt, er, dn, sb, dv, mk, tm);
    chk({name, " cnt"}, cnt, n);
    chk({name, " err"}, er, 1 - fin);
    chk({name, " done"}, dn, fin);
    chk({name, " sub"}, sb, nz);
    chk({name, " div"}, dv, n);
    chk({name, " mask"}, mk, 2 * nz + fin);
    chk({name, " term"}, tm, fin);
  endtask

  typedef struct {
    logic [15:0] digs;
    int len, rmode, e_cnt, e_done, e_err, e_sub, e_mask;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt, er, dn, sb, dv, mk, tm, w;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tbl[0] = '{16'h0000, 0, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{16'h0000, 1, 1, 1, 1, 0, 0, 1};
    tbl[2] = '{16'h0003, 1, 0, 1, 1, 0, 1, 3};
    tbl[3] = '{16'h0031, 3, 1, 3, 1, 0, 2, 5};
    tbl[4] = '{16'h0000, 4, 0, 4, 0, 1, 0, 0};
    tbl[5] = '{16'h0007, 2, 1, 2, 1, 0, 2, 5};
    tbl[6] = '{16'h0555, 6, 1, 4, 0, 1, 4, 8};
    tbl[7] = '{16'h000C, 3, 0, 3, 1, 0, 1, 3};

    repeat (3) step();
    expv("reset outputs", 10'b0);
    chk("reset cnt", int'(digit_cnt), 0);
    chk("reset err", int'(err), 0);
    rst = 1'b0;

    // Zero scalar: exact cycle timing.
    pend.delete();
    begin
      int o0 = obs.size();
      start_pulse();
      expv("zero c1 load", 10'b1000000010); step();
      expv("zero c2 check", 10'b0000000010); step();
      expv("zero c3 final", 10'b0110000010); step();
      expv("zero c4 done", 10'b0000000001); step();
      expv("zero c5 idle", 10'b0000000000);
      chk("zero cnt", int'(digit_cnt), 0);
      chk("zero no digit", obs.size() - o0, 0);
    end

    // Even remainder: zero digit, straight to divide.
    pend.delete(); pend.push_back(2'b00);
    start_pulse();
    expv("even c1", 10'b1000000010); step();
    expv("even c2", 10'b0000000010); step();
    expv("even c3 emit", 10'b0000010010); step();
    expv("even c4 div", 10'b0000100010);
    chk("even cnt before", int'(digit_cnt), 0); step();
    expv("even c5 check", 10'b0000000010);
    chk("even cnt after", int'(digit_cnt), 1); step();
    expv("even c6 final", 10'b0110000010); step();
    expv("even c7 done", 10'b0000000001);

    // Odd negative digit with 5 stalled cycles in EMIT.
    rdy_mode = 2; man_ready = 1'b0;
    pend.delete(); pend.push_back(2'b11);
    start_pulse();
    expv("odd c1", 10'b1000000010); step();
    expv("odd c2", 10'b0000000010); step();
    expv("odd c3 mask1", 10'b0100000010); step();
    expv("odd c4 mask2", 10'b0100000010); step();
    for (int i = 0; i < 6; i++) begin
      expv($sformatf("odd emit hold %0d", i), 10'b0000011110);
      if (i < 5) step();
    end
    man_ready = 1'b1; step();
    expv("odd sub", 10'b0001000010); step();
    expv("odd div", 10'b0000100010); step();
    expv("odd check", 10'b0000000010);
    chk("odd cnt", int'(digit_cnt), 1); step();
    expv("odd final", 10'b0110000010); step();
    expv("odd done", 10'b0000000001);
    rdy_mode = 0;

    // Table-driven runs with fixed expectations.
    for (int t = 0; t < 8; t++) begin
      string nm = $sformatf("tbl%0d", t);
      pend.delete();
      for (int i = 0; i < tbl[t].len; i++) pend.push_back(tbl[t].digs[2*i +: 2]);
      rdy_mode = tbl[t].rmode;
      do_run(nm, cnt, er, dn, sb, dv, mk, tm);
      chk({nm, " cnt"}, cnt, tbl[t].e_cnt);
      chk({nm, " done"}, dn, tbl[t].e_done);
      chk({nm, " err"}, er, tbl[t].e_err);
      chk({nm, " sub"}, sb, tbl[t].e_sub);
      chk({nm, " mask"}, mk, tbl[t].e_mask);
      chk({nm, " busy"}, int'(busy), 0);
    end

    // Random digit strings and random backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 12; r++) begin
      int len = $urandom_range(0, 6);
      pend.delete();
      for (int i = 0; i < len; i++) begin
        int s = $urandom_range(0, 2);
        pend.push_back(s == 0 ? 2'b00 : (s == 1 ? 2'b01 : 2'b11));
      end
      run_model($sformatf("rnd%0d", r));
    end
    rdy_mode = 0;

    // Abort in MASK2.
    pend.delete(); pend.push_back(2'b01);
    start_pulse(); step(); step(); step();
    expv("abort at mask2", 10'b0100000010);
    abort = 1'b1; step();
    expv("abort idle", 10'b0000000000);
    abort = 1'b0;
    chk("abort cnt", int'(digit_cnt), 0);
    run_model("post abort");

    // Asynchronous reset in EMIT after two digits.
    pend.delete(); pend.push_back(2'b00); pend.push_back(2'b00); pend.push_back(2'b01);
    start_pulse();
    w = 0;
    while (!(digit_valid && digit_cnt == CW'(2)) && w < 50) begin step(); w++; end
    chk("reach third emit", int'(w < 50), 1);
    rst = 1'b1; #1;
    expv("rst immediate", 10'b0000000000);
    chk("rst cnt", int'(digit_cnt), 0);
    step(); rst = 1'b0; step();
    run_model("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tnaf_digit_ctrl.md
Name: tnaf_digit_ctrl

Overview:
Sequencer for the tau-NAF digit generation loop of the Koblitz scalar recoder. It drives the d-masking unit (two-cycle mask enable, terminal flush), the remainder subtract/divide-by-tau datapath, and a ready/valid digit output stream to the digit buffer. One scalar is recoded per start; the block counts digits and flags runaway recoding.

Parameters:
MAX_DIGITS, 290, digit limit before err_overflow (K-283 tau-NAF length plus margin)
CNT_W, 9, width of digit_cnt; must satisfy 2**CNT_W > MAX_DIGITS

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin recoding; sampled only in IDLE/DONE/ERR
abort  in  1  synchronous abort to IDLE from any state
load_en  out  1  one-cycle load of scalar into remainder registers
r_zero  in  1  remainder (both components) equals zero
r_odd  in  1  remainder needs a nonzero digit (r0 lsb = 1)
mask_d_en  out  1  enable to d-masking unit
terminal_condition  out  1  terminal flush strobe to d-masking unit
tbit  in  1  signed digit bit from masking unit (1 = negative)
sub_en  out  1  one-cycle subtract of emitted digit from remainder
div_en  out  1  one-cycle divide-by-tau of remainder
digit_valid  out  1  digit available
digit_ready  in  1  downstream accepts digit
digit_nz  out  1  digit is nonzero
digit_sign  out  1  digit sign (valid when digit_nz)
digit_cnt  out  CNT_W  digits emitted this run
busy  out  1  high in every state except IDLE/DONE/ERR
done  out  1  one-cycle completion pulse
err_overflow  out  1  sticky until next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0, digit_cnt 0.
- States: IDLE, LOAD, CHECK, MASK1, MASK2, EMIT, SUB, DIV, FINAL, DONE, ERR.
- IDLE/DONE/ERR + start: -> LOAD; clear digit_cnt, err_overflow.
- LOAD: load_en=1 -> CHECK. Datapath flags valid the cycle after load_en/div_en; CHECK relies on this.
- CHECK: r_zero -> FINAL; else r_odd -> MASK1; else -> EMIT with zero digit (nz latch 0, sign 0).
- MASK1, MASK2: mask_d_en=1 both cycles, exactly two consecutive (masking unit updates carry/Tbit on the second). MASK2 -> EMIT with nz latch 1.
- EMIT: digit_valid=1; digit_nz = nz latch; digit_sign = tbit sampled in EMIT first cycle and held registered; values stable while digit_ready=0. On valid&ready: -> SUB if nz else -> DIV.
- SUB: sub_en=1 -> DIV.
- DIV: div_en=1; digit_cnt+1. If new count == MAX_DIGITS -> ERR (err_overflow=1, no done); else -> CHECK.
- FINAL: mask_d_en=1 and terminal_condition=1 for one cycle -> DONE.
- DONE: done=1 for the entry cycle only; remains DONE (busy=0) until start.
- ERR: holds err_overflow=1; start restarts.
- abort (any state, priority over all transitions): -> IDLE next cycle; deassert all strobes; digit_cnt held; no done.
- start while busy: ignored.
- rst mid-run: immediate return to IDLE and reset values; partial digits are discarded downstream.
- Strobes load_en, mask_d_en, terminal_condition, sub_en, div_en are registered decodes of state; at most one of load_en/sub_en/div_en high per cycle.

Test Plan:
- Zero scalar: start at edge 0, r_zero=1 after load -> load_en cycle 1, CHECK cycle 2, mask_d_en&terminal_condition cycle 3, done cycle 4, digit_cnt=0, no digit_valid.
- Even remainder, r_odd=0, digit_ready=1: -> digit_valid with nz=0, no mask_d_en, no sub_en, div_en next cycle, digit_cnt 0->1.
- Odd remainder, tbit=1: mask_d_en exactly 2 consecutive cycles, then digit_valid nz=1 sign=1, sub_en then div_en on the following two cycles.
- Backpressure: digit_ready low 5 cycles in EMIT -> digit_valid/nz/sign stable 6 cycles, no sub_en/div_en until handshake.
- MAX_DIGITS=4, r_zero never set -> 4 div_en pulses, ERR, err_overflow=1, busy=0, done never pulsed; next start clears err.
- abort in MASK2 and async rst in EMIT -> IDLE next cycle/immediately, all strobes 0, done=0; fresh start recodes normally.
